// File: rtl/tmds_encoder.sv
// tmds_encoder
//   Encodes one RGB pixel per clock into three 10-bit DVI TMDS symbols.
//   During active video (data_enable=1) each channel is 8b/10b encoded with
//   running DC balance. During blanking, 2-bit control codes are sent.
//   Pipeline latency is 2 + REG_INPUT clocks. There are no stalls.
//
// Ports
//   clk          pixel clock
//   reset        asynchronous assert, active-high
//   data_red     8-bit red component   (channel 2)
//   data_green   8-bit green component (channel 1)
//   data_blue    8-bit blue component  (channel 0)
//   data_enable  1 = active video, 0 = control period
//   hSync/vSync  sent as C0/C1 on the blue channel during blanking
//   tmds_red     channel 2 symbol (bit 0 transmitted first)
//   tmds_green   channel 1 symbol
//   tmds_blue    channel 0 symbol
module tmds_encoder #(
    parameter int REG_INPUT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_red,
    input  logic [7:0] data_green,
    input  logic [7:0] data_blue,
    input  logic       data_enable,
    input  logic       hSync,
    input  logic       vSync,
    output logic [9:0] tmds_red,
    output logic [9:0] tmds_green,
    output logic [9:0] tmds_blue
);

    localparam logic [9:0] CTRL_00 = 10'h354;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimising stage: q[8]=1 marks XOR coding, 0 marks XNOR.
    function automatic logic [8:0] transition_min(input logic [7:0] d);
        logic [8:0] q;
        logic [3:0] n;
        logic       use_xnor;
        n        = ones8(d);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = 10'h354;
            2'b01:   s = 10'h0AB;
            2'b10:   s = 10'h154;
            default: s = 10'h2AB;
        endcase
        return s;
    endfunction

    // Channel index follows DVI numbering: 0 blue, 1 green, 2 red.
    logic [7:0] raw_data [3];
    logic [7:0] in_data  [3];
    logic       in_de;
    logic [1:0] in_ctrl;
    logic [9:0] sym_out  [3];

    assign raw_data[0] = data_blue;
    assign raw_data[1] = data_green;
    assign raw_data[2] = data_red;

    // ---------------- S0: optional input register ----------------
    generate
        if (REG_INPUT != 0) begin : g_in_reg
            logic [7:0] data_q [3];
            logic       de_q;
            logic [1:0] ctrl_q;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < 3; i++) begin
                        data_q[i] <= '0;
                    end
                    de_q   <= 1'b0;
                    ctrl_q <= 2'b00;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        data_q[i] <= raw_data[i];
                    end
                    de_q   <= data_enable;
                    ctrl_q <= {vSync, hSync};
                end
            end

            assign in_data = data_q;
            assign in_de   = de_q;
            assign in_ctrl = ctrl_q;
        end else begin : g_in_direct
            assign in_data = raw_data;
            assign in_de   = data_enable;
            assign in_ctrl = {vSync, hSync};
        end
    endgenerate

    // ---------------- S1 shared control pipeline ----------------
    logic       s1_de_q;
    logic [1:0] s1_ctrl_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_de_q   <= 1'b0;
            s1_ctrl_q <= 2'b00;
        end else begin
            s1_de_q   <= in_de;
            s1_ctrl_q <= in_ctrl;
        end
    end

    // ---------------- Per-channel S1 + S2 ----------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ch
            logic [8:0]        qm_d, qm_q;
            logic [3:0]        n1_d, n1_q;
            logic signed [4:0] cnt_d, cnt_q;
            logic signed [4:0] diff;        // N1 - N0 of the registered q_m
            logic [9:0]        sym_d, sym_q;
            logic [1:0]        ch_ctrl;

            assign qm_d = transition_min(in_data[gi]);
            assign n1_d = ones8(qm_d[7:0]);

            // Only blue carries the sync bits; red and green always send ctrl 00.
            assign ch_ctrl = (gi == 0) ? s1_ctrl_q : 2'b00;

            // N1 - N0 = 2*N1 - 8; range -8..8, so 5-bit signed is exact.
            assign diff = $signed({n1_q, 1'b0} - 5'd8);

            always_comb begin
                cnt_d = cnt_q;
                sym_d = CTRL_00;
                if (!s1_de_q) begin
                    cnt_d = '0;
                    sym_d = ctrl_symbol(ch_ctrl);
                end else if ((cnt_q == 5'sd0) || (n1_q == 4'd4)) begin
                    sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
                    cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
                end else if (((cnt_q > 5'sd0) && (n1_q > 4'd4)) ||
                             ((cnt_q < 5'sd0) && (n1_q < 4'd4))) begin
                    // Invert the data to pull the running disparity back toward zero.
                    sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
                    cnt_d = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - diff;
                end else begin
                    sym_d = {1'b0, qm_q[8], qm_q[7:0]};
                    cnt_d = cnt_q - (qm_q[8] ? 5'sd0 : 5'sd2) + diff;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    qm_q  <= '0;
                    n1_q  <= '0;
                    cnt_q <= '0;
                    sym_q <= CTRL_00;
                end else begin
                    qm_q  <= qm_d;
                    n1_q  <= n1_d;
                    cnt_q <= cnt_d;
                    sym_q <= sym_d;
                end
            end

            assign sym_out[gi] = sym_q;
        end
    endgenerate

    assign tmds_blue  = sym_out[0];
    assign tmds_green = sym_out[1];
    assign tmds_red   = sym_out[2];

endmodule

// File: tb/tb_tmds_encoder.sv
// tb_tmds_encoder
//   Directed, table-driven bench for tmds_encoder: a vector table of
//   {inputs, expected symbols} applied one per clock and compared L clocks
//   later, plus hand-written reset sequences (power-up and mid-line).
module tb_tmds_encoder;

    localparam int REG_INPUT = 1;
    localparam int L         = 2 + REG_INPUT;
    localparam int NV        = 19;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_red = '0;
    logic [7:0] data_green = '0;
    logic [7:0] data_blue = '0;
    logic       data_enable = 1'b0;
    logic       hSync = 1'b0;
    logic       vSync = 1'b0;
    logic [9:0] tmds_red;
    logic [9:0] tmds_green;
    logic [9:0] tmds_blue;

    int n_applied    = 0;
    int n_miscompare = 0;

    typedef struct {
        logic [7:0] r, g, b;
        logic       de, hs, vs;
        logic [9:0] er, eg, eb;
    } vec_t;

    vec_t vecs [NV];

    tmds_encoder #(.REG_INPUT(REG_INPUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_red    (data_red),
        .data_green  (data_green),
        .data_blue   (data_blue),
        .data_enable (data_enable),
        .hSync       (hSync),
        .vSync       (vSync),
        .tmds_red    (tmds_red),
        .tmds_green  (tmds_green),
        .tmds_blue   (tmds_blue)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                input logic de, input logic hs, input logic vs,
                                input logic [9:0] er, input logic [9:0] eg, input logic [9:0] eb);
        vec_t v;
        v.r = r;  v.g = g;  v.b = b;
        v.de = de; v.hs = hs; v.vs = vs;
        v.er = er; v.eg = eg; v.eb = eb;
        return v;
    endfunction

    task automatic drive(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic de, input logic hs, input logic vs);
        data_red    = r;
        data_green  = g;
        data_blue   = b;
        data_enable = de;
        hSync       = hs;
        vSync       = vs;
    endtask

    task automatic check(input string name, input logic [9:0] er, input logic [9:0] eg,
                         input logic [9:0] eb);
        n_applied++;
        if (tmds_red !== er || tmds_green !== eg || tmds_blue !== eb) begin
            n_miscompare++;
            $display("FAIL %s: got r=%03h g=%03h b=%03h, want r=%03h g=%03h b=%03h",
                     name, tmds_red, tmds_green, tmds_blue, er, eg, eb);
        end else begin
            $display("%s: r=%03h g=%03h b=%03h ok", name, tmds_red, tmds_green, tmds_blue);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Expected symbols worked out by hand from the encoding rules.
        // Running disparity per channel noted as r/g/b after each symbol.
        vecs[0]  = mk(8'h00, 8'h00, 8'h00, 0, 0, 0, 10'h354, 10'h354, 10'h354);
        vecs[1]  = mk(8'h00, 8'h00, 8'h00, 0, 1, 0, 10'h354, 10'h354, 10'h0AB);
        vecs[2]  = mk(8'h00, 8'h00, 8'h00, 0, 0, 1, 10'h354, 10'h354, 10'h154);
        vecs[3]  = mk(8'h00, 8'h00, 8'h00, 0, 1, 1, 10'h354, 10'h354, 10'h2AB);
        vecs[4]  = mk(8'hFF, 8'h00, 8'h00, 1, 0, 0, 10'h200, 10'h100, 10'h100); // -8/-8/-8
        vecs[5]  = mk(8'hFF, 8'h00, 8'h00, 1, 0, 0, 10'h0FF, 10'h3FF, 10'h3FF); // -2/+2/+2
        vecs[6]  = mk(8'hFF, 8'h00, 8'h00, 1, 0, 0, 10'h0FF, 10'h100, 10'h100); // +4/-6/-6
        vecs[7]  = mk(8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 10'h354, 10'h354, 10'h354); // cleared
        vecs[8]  = mk(8'hFF, 8'h00, 8'h00, 1, 0, 0, 10'h200, 10'h100, 10'h100); // -8/-8/-8
        vecs[9]  = mk(8'h00, 8'h00, 8'h00, 0, 1, 0, 10'h354, 10'h354, 10'h0AB); // cleared
        vecs[10] = mk(8'hFF, 8'h00, 8'h00, 1, 0, 0, 10'h200, 10'h100, 10'h100); // -8/-8/-8
        vecs[11] = mk(8'h55, 8'hAA, 8'h55, 1, 0, 0, 10'h133, 10'h233, 10'h133); // balanced, -8
        vecs[12] = mk(8'h01, 8'h01, 8'h01, 1, 0, 0, 10'h1FF, 10'h1FF, 10'h1FF); // 0
        vecs[13] = mk(8'h01, 8'h01, 8'h01, 1, 0, 0, 10'h1FF, 10'h1FF, 10'h1FF); // +8
        vecs[14] = mk(8'h01, 8'h01, 8'h01, 1, 0, 0, 10'h300, 10'h300, 10'h300); // +2
        vecs[15] = mk(8'h00, 8'h00, 8'h00, 1, 0, 0, 10'h100, 10'h100, 10'h100); // -6
        vecs[16] = mk(8'hFF, 8'hFF, 8'hFF, 1, 0, 0, 10'h0FF, 10'h0FF, 10'h0FF); // 0
        vecs[17] = mk(8'h00, 8'h00, 8'h00, 1, 1, 1, 10'h100, 10'h100, 10'h100); // sync ignored
        vecs[18] = mk(8'hFF, 8'hFF, 8'hFF, 0, 0, 1, 10'h354, 10'h354, 10'h154); // data ignored

        // Power-up reset with blanking inputs, then hold through release.
        drive(8'h00, 8'h00, 8'h00, 0, 0, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_state", 10'h354, 10'h354, 10'h354);
        reset = 1'b0;
        repeat (L + 1) @(negedge clk);
        check("after_release_idle", 10'h354, 10'h354, 10'h354);

        // Table: vector i driven at iteration i, its symbols appear at iteration i+L.
        for (int i = 0; i < NV + L; i++) begin
            @(negedge clk);
            if (i >= L) begin
                check($sformatf("vec%0d", i - L), vecs[i-L].er, vecs[i-L].eg, vecs[i-L].eb);
            end
            if (i < NV) begin
                drive(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].de, vecs[i].hs, vecs[i].vs);
            end else begin
                drive(8'h00, 8'h00, 8'h00, 0, 0, 0);
            end
        end

        // Mid-line reset: leave cnt at -8, then reset asynchronously between edges.
        @(negedge clk);
        drive(8'h00, 8'h00, 8'h00, 1, 0, 0);
        repeat (L) @(negedge clk);
        check("midline_first_pixel", 10'h100, 10'h100, 10'h100);
        #2;
        reset = 1'b1;
        #1;
        check("midline_async_reset", 10'h354, 10'h354, 10'h354);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < L - 1; k++) begin
            @(negedge clk);
            check($sformatf("refill%0d", k), 10'h354, 10'h354, 10'h354);
        end
        // A stale cnt of -8 would produce 0x3FF here; a cleared one gives 0x100.
        @(negedge clk);
        check("post_reset_pixel0", 10'h100, 10'h100, 10'h100);
        @(negedge clk);
        check("post_reset_pixel1", 10'h3FF, 10'h3FF, 10'h3FF);

        drive(8'h00, 8'h00, 8'h00, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
